// File: rtl/div_radix2_pkg.sv
// Shared definitions for the radix-2 restoring divider: default operand width and FSM encodings.
package div_radix2_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signed/unsigned,
// returns {remainder, quotient} with a one-cycle ready pulse.
module div_radix2
  import div_radix2_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               valid,
  input  logic               sign,
  output logic               div_stall,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e state_q, state_d;

  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sign_q, sign_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  // Operand magnitudes; negation wraps so -2^(W-1) maps to itself and is read as unsigned.
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (sign && a[WIDTH-1]) ? (-a) : a;
  assign b_mag = (sign && b[WIDTH-1]) ? (-b) : b;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] fix_rem, fix_quo;

  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, divisor_q};
    rem_ge    = (rem_shift >= {1'b0, divisor_q});
    step_rem  = rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    step_quo  = {quo_q[WIDTH-2:0], rem_ge};
    fix_quo   = (sign_q && neg_quo_q) ? (-step_quo) : step_quo;
    fix_rem   = (sign_q && neg_rem_q) ? (-step_rem) : step_rem;
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    count_d   = count_q;
    sign_d    = sign_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    div_stall = 1'b0;
    ready     = 1'b0;

    unique case (state_q)
      DIV_IDLE: begin
        div_stall = valid;
        if (valid) begin
          quo_d     = a_mag;
          divisor_d = b_mag;
          rem_d     = '0;
          count_d   = '0;
          sign_d    = sign;
          neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
          neg_rem_d = a[WIDTH-1];
          state_d   = DIV_CALC;
        end
      end
      DIV_CALC: begin
        div_stall = 1'b1;
        rem_d     = step_rem;
        quo_d     = step_quo;
        count_d   = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          result_d = {fix_rem, fix_quo};
          state_d  = DIV_DONE;
        end
      end
      DIV_DONE: begin
        ready   = 1'b1;
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    // Execute-stage flush wins over any request or in-flight step.
    if (flush) begin
      state_d   = DIV_IDLE;
      rem_d     = rem_q;
      quo_d     = quo_q;
      divisor_d = divisor_q;
      count_d   = count_q;
      sign_d    = sign_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      div_stall = 1'b0;
      ready     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      sign_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      count_q   <= count_d;
      sign_q    <= sign_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_div_radix2.sv
// Directed-vector bench for div_radix2: hand-computed results, stall length, ready pulses,
// flush and reset behaviour.
module tb_div_radix2;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        valid;
  logic        sign;
  logic        div_stall;
  logic        ready;
  logic [63:0] result;

  int n_cmp;
  int n_err;
  int ready_cnt;

  div_radix2 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .a         (a),
    .b         (b),
    .valid     (valid),
    .sign      (sign),
    .div_stall (div_stall),
    .ready     (ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ready) ready_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at posedge+1 with the DUT in IDLE; returns at the negedge of the DONE cycle.
  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic sv, input logic [63:0] exp);
    int stall_cnt;
    stall_cnt = 0;
    a     = av;
    b     = bv;
    sign  = sv;
    valid = 1'b1;
    @(negedge clk);
    while (div_stall && stall_cnt < 100) begin
      stall_cnt++;
      @(negedge clk);
    end
    $display("op %s: a=%h b=%h sign=%0d stall=%0d result=%h", tag, av, bv, sv, stall_cnt, result);
    check({tag, "_stall"}, 64'(stall_cnt), 64'd33);
    check({tag, "_ready"}, 64'(ready), 64'd1);
    check({tag, "_result"}, result, exp);
  endtask

  task automatic finish_op(input string tag);
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    check({tag, "_ready_drop"}, 64'(ready), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] saved;
    int          rc;
    n_cmp = 0;
    n_err = 0;
    ready_cnt = 0;
    rst = 1'b1;
    flush = 1'b0;
    valid = 1'b0;
    sign = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_result", result, 64'h0);
    check("rst_stall", 64'(div_stall), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_op("u7div2", 32'd7, 32'd2, 1'b0, {32'h1, 32'h3});
    finish_op("u7div2");
    check("u7div2_pulses", 64'(ready_cnt), 64'd1);

    do_op("sm7div2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    finish_op("sm7div2");
    do_op("s7divm2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h1, 32'hFFFF_FFFD});
    finish_op("s7divm2");

    do_op("u5div0", 32'd5, 32'd0, 1'b0, {32'h5, 32'hFFFF_FFFF});
    finish_op("u5div0");

    do_op("sminm1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000});
    finish_op("sminm1");
    do_op("umaxd16", 32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF});
    finish_op("umaxd16");

    // Request colliding with flush in IDLE must not be accepted.
    valid = 1'b1;
    flush = 1'b1;
    a = 32'd9;
    b = 32'd3;
    @(negedge clk);
    check("idle_flush_stall", 64'(div_stall), 64'd0);
    @(posedge clk);
    #1;
    valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("idle_flush_noaccept", 64'(div_stall), 64'd0);
    @(posedge clk);
    #1;

    // Flush on the 10th CALC cycle.
    saved = result;
    rc = ready_cnt;
    a = 32'd50;
    b = 32'd3;
    sign = 1'b0;
    valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    check("flush_stall", 64'(div_stall), 64'd0);
    check("flush_ready", 64'(ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle_stall", 64'(div_stall), 64'd0);
    check("flush_result_kept", result, saved);
    check("flush_no_pulse", 64'(ready_cnt), 64'(rc));
    @(posedge clk);
    #1;
    do_op("u100div7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE});
    finish_op("u100div7");

    // Reset in the middle of CALC.
    rc = ready_cnt;
    a = 32'd1000;
    b = 32'd3;
    valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_result", result, 64'h0);
    check("midrst_stall", 64'(div_stall), 64'd0);
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_no_pulse", 64'(ready_cnt), 64'(rc));
    @(posedge clk);
    #1;

    // Back-to-back with valid held through DONE.
    rc = ready_cnt;
    do_op("u6div3", 32'd6, 32'd3, 1'b0, {32'h0, 32'h2});
    a = 32'd9;
    b = 32'd4;
    @(posedge clk);
    #1;
    do_op("u9div4", 32'd9, 32'd4, 1'b0, {32'h1, 32'h2});
    finish_op("u9div4");
    check("b2b_pulses", 64'(ready_cnt - rc), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
